// File: rtl/xswitch_pkg.sv
// Shared types and constants for the xswitch egress path.
// Optional feature macro used by this slice: XSWITCH_EGRESS_STATS_EN.
package xswitch_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    // One buffered word: the source port tag travels with its payload.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] src;
        logic [DEF_DATA_W-1:0] data;
    } egress_word_t;

endpackage

// File: rtl/xswitch_egress_buffer_if.sv
// Bus bundle of the egress buffer: switch-side word handshake plus the
// consumer-side valid/ready stream and occupancy status.
// The buffer connects through the slave modport, its environment through master.
interface xswitch_egress_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Switch side
    logic              valid_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              data_rd;

    // Consumer side
    logic              out_valid;
    logic [ADDR_W-1:0] out_src;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Status
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport master (
        output valid_out, addr_out, data_out, out_ready,
        input  data_rd, out_valid, out_src, out_data, full, empty, count
    );

    modport slave (
        input  valid_out, addr_out, data_out, out_ready,
        output data_rd, out_valid, out_src, out_data, full, empty, count
    );
endinterface

// File: rtl/xswitch_sync_fifo.sv
// Show-ahead synchronous FIFO of egress_word_t. The head entry is always
// presented on o_rdata; pointers carry one extra wrap bit to tell full
// from empty.
module xswitch_sync_fifo
    import xswitch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  egress_word_t             i_wdata,
    input  logic                     i_pop,
    output egress_word_t             o_rdata,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_count;
    egress_word_t     r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_push  = i_push & (~w_full | w_pop);

    // Pointer and occupancy update; both pointers wrap modulo 2*DEPTH naturally.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers alone
        // define which entries are meaningful, and reset-free RAM maps to memory cells.
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_valid = ~w_empty;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
endmodule

// File: rtl/xswitch_egress_buffer.sv
// Per-port receive buffer downstream of the 4x4 xswitch. Accepts words with a
// same-cycle data_rd acknowledge, queues them with their source tag and
// offers them to the consumer in strict arrival order.
// Define XSWITCH_EGRESS_STATS_EN to add per-source and stall counters.
module xswitch_egress_buffer
    import xswitch_pkg::*;
#(
    // The stored word layout is egress_word_t, so these must match its field widths.
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    xswitch_egress_buffer_if.slave    bus
`ifdef XSWITCH_EGRESS_STATS_EN
    ,
    output logic [15:0]               stat_src_cnt [NUM_PORTS],
    output logic [15:0]               stat_stall_cnt
`endif
);
    logic         w_data_rd;
    logic         w_full;
    egress_word_t w_wr_word;
    egress_word_t w_rd_word;

    // Accept when room exists, or when the head leaves in this same cycle.
    assign w_data_rd = reset & bus.valid_out & (~w_full | bus.out_ready);

    // Pack the presented word with its source tag.
    always_comb begin
        // NOTE: every field gets a value on every path so no latch is inferred.
        w_wr_word      = '0;
        w_wr_word.src  = bus.addr_out;
        w_wr_word.data = bus.data_out;
    end

    xswitch_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_data_rd),
        .i_wdata (w_wr_word),
        .i_pop   (bus.out_ready),
        .o_rdata (w_rd_word),
        .o_valid (bus.out_valid),
        .o_full  (w_full),
        .o_empty (bus.empty),
        .o_count (bus.count)
    );

    assign bus.data_rd  = w_data_rd;
    assign bus.full     = w_full;
    assign bus.out_src  = w_rd_word.src;
    assign bus.out_data = w_rd_word.data;

`ifdef XSWITCH_EGRESS_STATS_EN
    logic [15:0] r_src_cnt [NUM_PORTS];
    logic [15:0] r_stall_cnt;

    // Saturating per-source accept counters and stall-cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) r_src_cnt[i] <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_data_rd && (r_src_cnt[bus.addr_out] != 16'hFFFF))
                r_src_cnt[bus.addr_out] <= r_src_cnt[bus.addr_out] + 16'd1;
            if (bus.valid_out && !w_data_rd && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stat_src_cnt   = r_src_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_xswitch_egress_buffer.sv
// Directed bench for xswitch_egress_buffer. Inputs change on the falling
// edge; outputs are sampled just after that, away from the rising edge.
module tb_xswitch_egress_buffer;
    import xswitch_pkg::*;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    xswitch_egress_buffer_if #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) bus ();

`ifdef XSWITCH_EGRESS_STATS_EN
    logic [15:0] stat_src_cnt [NUM_PORTS];
    logic [15:0] stat_stall_cnt;
`endif

    xswitch_egress_buffer #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef XSWITCH_EGRESS_STATS_EN
        ,
        .stat_src_cnt   (stat_src_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.valid_out = 1'b0;
        bus.addr_out  = '0;
        bus.data_out  = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        bus.valid_out = 1'b1;
        bus.data_out  = 8'hEE;
        #1;
        n_total++; if (bus.data_rd !== 1'b0) $display("FAIL rst_data_rd got %0b want 0", bus.data_rd); else n_pass++;
        n_total++; if (bus.empty !== 1'b1) $display("FAIL rst_empty got %0b want 1", bus.empty); else n_pass++;
        n_total++; if (bus.count !== 3'd0) $display("FAIL rst_count got %0d want 0", bus.count); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.full !== 1'b0) $display("FAIL rst_full got %0b want 0", bus.full); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (bus.empty !== 1'b1) $display("FAIL idle_empty got %0b want 1", bus.empty); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.valid_out = 1'b1;
            bus.addr_out  = 2'(i);
            bus.data_out  = 8'(8'hA0 + i);
            #1;
            n_total++; if (bus.data_rd !== 1'b1) $display("FAIL fill_data_rd[%0d] got %0b want 1", i, bus.data_rd); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (bus.full !== 1'b1) $display("FAIL fill_full got %0b want 1", bus.full); else n_pass++;
        n_total++; if (bus.count !== 3'd4) $display("FAIL fill_count got %0d want 4", bus.count); else n_pass++;
        n_total++; if (bus.out_data !== 8'hA0 || bus.out_src !== 2'd0) $display("FAIL fill_head got %0h/%0d want a0/0", bus.out_data, bus.out_src); else n_pass++;
        bus.addr_out = 2'd2;
        bus.data_out = 8'hEE;
        #1;
        n_total++; if (bus.data_rd !== 1'b0) $display("FAIL fill_backpressure got %0b want 0", bus.data_rd); else n_pass++;
        @(negedge clk);
        bus.valid_out = 1'b0;
        n_total++; if (bus.count !== 3'd4) $display("FAIL fill_no_drop_count got %0d want 4", bus.count); else n_pass++;
`ifdef XSWITCH_EGRESS_STATS_EN
        n_total++; if (stat_stall_cnt !== 16'd1) $display("FAIL stat_stall got %0d want 1", stat_stall_cnt); else n_pass++;
        for (int i = 0; i < NUM_PORTS; i++) begin
            n_total++; if (stat_src_cnt[i] !== 16'd1) $display("FAIL stat_src[%0d] got %0d want 1", i, stat_src_cnt[i]); else n_pass++;
        end
`endif
    endtask

    task automatic test_drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'hA0 + i) || bus.out_src !== 2'(i))
                $display("FAIL drain[%0d] got v%0b %0h/%0d want v1 %0h/%0d", i, bus.out_valid, bus.out_data, bus.out_src, 8'(8'hA0 + i), i);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_total++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) $display("FAIL drain_empty got e%0b c%0d want e1 c0", bus.empty, bus.count); else n_pass++;
        // out_ready held while empty must not disturb the state.
        @(negedge clk);
        n_total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) $display("FAIL empty_pop got c%0d v%0b want c0 v0", bus.count, bus.out_valid); else n_pass++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_simul();
        logic [7:0] exp_q [5];
        exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h55};
        for (int i = 0; i < 4; i++) begin
            bus.valid_out = 1'b1;
            bus.addr_out  = 2'(3 - i);
            bus.data_out  = exp_q[i];
            @(negedge clk);
        end
        bus.addr_out  = 2'd1;
        bus.data_out  = 8'h55;
        bus.out_ready = 1'b1;
        #1;
        n_total++; if (bus.data_rd !== 1'b1) $display("FAIL simul_data_rd got %0b want 1", bus.data_rd); else n_pass++;
        @(negedge clk);
        bus.valid_out = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_total++; if (bus.count !== 3'd4 || bus.full !== 1'b1) $display("FAIL simul_count got c%0d f%0b want c4 f1", bus.count, bus.full); else n_pass++;
        bus.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            n_total++; if (bus.out_data !== exp_q[i]) $display("FAIL simul_order[%0d] got %0h want %0h", i, bus.out_data, exp_q[i]); else n_pass++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        #1;
        n_total++; if (bus.empty !== 1'b1) $display("FAIL simul_empty got %0b want 1", bus.empty); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.valid_out = 1'b1;
            bus.addr_out  = 2'(k);
            bus.data_out  = 8'(8'h10 + k);
            #1;
            if (bus.data_rd !== 1'b1) errs++;
            if (k > 0 && (bus.count !== 3'd1 || bus.out_data !== 8'(8'h10 + k - 1) || bus.out_src !== 2'(k - 1))) begin
                errs++;
                $display("FAIL stream[%0d] got c%0d %0h want c1 %0h", k, bus.count, bus.out_data, 8'(8'h10 + k - 1));
            end
            @(negedge clk);
        end
        bus.valid_out = 1'b0;
        #1;
        n_total++; if (errs != 0) $display("FAIL stream_errors got %0d want 0", errs); else n_pass++;
        n_total++; if (bus.out_data !== 8'h23 || bus.count !== 3'd1) $display("FAIL stream_last got %0h c%0d want 23 c1", bus.out_data, bus.count); else n_pass++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_total++; if (bus.empty !== 1'b1) $display("FAIL stream_empty got %0b want 1", bus.empty); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            bus.valid_out = 1'b1;
            bus.addr_out  = 2'(i);
            bus.data_out  = 8'(8'hC0 + i);
            @(negedge clk);
        end
        bus.valid_out = 1'b0;
        #1;
        n_total++; if (bus.count !== 3'd3) $display("FAIL mid_count_pre got %0d want 3", bus.count); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) $display("FAIL mid_reset got c%0d v%0b want c0 v0", bus.count, bus.out_valid); else n_pass++;
`ifdef XSWITCH_EGRESS_STATS_EN
        n_total++; if (stat_src_cnt[0] !== 16'd0 || stat_stall_cnt !== 16'd0) $display("FAIL mid_stats got %0d/%0d want 0/0", stat_src_cnt[0], stat_stall_cnt); else n_pass++;
`endif
        bus.valid_out = 1'b1;
        bus.addr_out  = 2'd3;
        bus.data_out  = 8'h7E;
        @(negedge clk);
        bus.valid_out = 1'b0;
        #1;
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h7E || bus.out_src !== 2'd3 || bus.count !== 3'd1)
            $display("FAIL mid_first got v%0b %0h/%0d c%0d want v1 7e/3 c1", bus.out_valid, bus.out_data, bus.out_src, bus.count);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_fill();
        test_drain();
        test_full_simul();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
